// File: rtl/ud_cnt_param.sv
// ud_cnt_param
// Parametrised up/down counter with run-time modulus, wrap or saturate
// policy, enable prescaler, terminal-count pulse, sticky overflow flag and
// registered compare match.
//
// Parameters:
//   WIDTH      counter/data width in bits (>= 2)
//   SATURATE   0 = wrap at bounds, 1 = hold at bounds
//   PRESCALE_W prescaler divisor width in bits (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ce         count enable, feeds the prescaler
//   ld         synchronous load (wins over counting, ignores ce)
//   d          load value, clamped to max_val
//   ud         1 = count up, 0 = count down
//   max_val    upper bound; the counting range is 0..max_val
//   presc      one step per presc+1 enabled cycles
//   cmp_val    compare value
//   ovf_clr    clears the sticky overflow flag
//   q          current count
//   tc         one-cycle pulse after a step that hit a bound
//   ovf        sticky flag: a wrap or saturation has occurred
//   cmp_match  registered, high while q == cmp_val
module ud_cnt_param #(
    parameter int WIDTH      = 8,
    parameter bit SATURATE   = 1'b0,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  ld,
    input  logic [WIDTH-1:0]      d,
    input  logic                  ud,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [PRESCALE_W-1:0] presc,
    input  logic [WIDTH-1:0]      cmp_val,
    input  logic                  ovf_clr,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  ovf,
    output logic                  cmp_match
);

    logic [PRESCALE_W-1:0] pcnt;
    logic [PRESCALE_W-1:0] pcnt_nxt;
    logic [WIDTH-1:0]      q_nxt;
    logic                  step;
    logic                  hit;
    logic                  ovf_nxt;

    // Prescaler. The >= compare (rather than ==) makes a presc value lowered
    // below the running count step on the next enabled cycle instead of
    // running all the way round the prescaler.
    always_comb begin
        step     = 1'b0;
        pcnt_nxt = pcnt;
        if (ld) begin
            pcnt_nxt = '0;
        end else if (ce) begin
            if (pcnt >= presc) begin
                step     = 1'b1;
                pcnt_nxt = '0;
            end else begin
                pcnt_nxt = pcnt + 1'b1;
            end
        end
    end

    // Next count. A count left above a lowered max_val is pulled back to the
    // bound silently; only a step taken at a bound counts as a hit.
    always_comb begin
        q_nxt = q;
        hit   = 1'b0;
        if (ld) begin
            q_nxt = (d > max_val) ? max_val : d;
        end else if (step) begin
            if (q > max_val) begin
                q_nxt = max_val;
            end else if (ud) begin
                if (q == max_val) begin
                    hit   = 1'b1;
                    q_nxt = SATURATE ? q : '0;
                end else begin
                    q_nxt = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
                    hit   = 1'b1;
                    q_nxt = SATURATE ? q : max_val;
                end else begin
                    q_nxt = q - 1'b1;
                end
            end
        end
    end

    // A bound hit in the same cycle as ovf_clr keeps the flag set so that
    // the event is never lost.
    always_comb begin
        ovf_nxt = ovf;
        if (hit) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            pcnt      <= '0;
            tc        <= 1'b0;
            ovf       <= 1'b0;
            cmp_match <= 1'b0;
        end else begin
            q         <= q_nxt;
            pcnt      <= pcnt_nxt;
            tc        <= hit;
            ovf       <= ovf_nxt;
            // Compared against the next count so the flag lines up with q.
            cmp_match <= (q_nxt == cmp_val);
        end
    end

endmodule
